// File: rtl/vx_perf_pkg.sv
// Shared definitions for the performance counter bank: read word sizes,
// pipeline event channel numbering and the read-request record.
package vx_perf_pkg;

   localparam int PERF_RD_WORD_W = 32;
   localparam int PERF_CTR_MAX_W = 64;
   localparam int PERF_IDX_W     = 5;

   typedef enum logic [PERF_IDX_W-1:0] {
      PERF_LOADS      = 5'd0,
      PERF_STORES     = 5'd1,
      PERF_BRANCHES   = 5'd2,
      PERF_IBF_STALLS = 5'd3,
      PERF_SCB_STALLS = 5'd4,
      PERF_LSU_STALLS = 5'd5,
      PERF_CSR_STALLS = 5'd6,
      PERF_ALU_STALLS = 5'd7,
      PERF_FPU_STALLS = 5'd8,
      PERF_GPU_STALLS = 5'd9
   } perf_event_e;

   typedef struct packed {
      logic [PERF_IDX_W-1:0] idx;
      logic                  hi;
   } perf_rd_req_t;

endpackage

// File: rtl/vx_perf_counter.sv
// One event counter with enable, synchronous clear, multi-bit increment and a
// sticky overflow flag; wraps or saturates depending on SATURATE.
module vx_perf_counter
   import vx_perf_pkg::*;
#(
   parameter int CTR_WIDTH = 44,
   parameter int INC_WIDTH = 4,
   parameter int SATURATE  = 0
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 count_en,
   input  logic [INC_WIDTH-1:0] inc_amt,
   output logic [CTR_WIDTH-1:0] value,
   output logic                 ovf
);

   logic [CTR_WIDTH:0] sum;

   // One extra bit so the carry-out is the overflow indication
   always_comb begin
      sum = {1'b0, value} + (CTR_WIDTH+1)'(inc_amt);
   end

   // Counter and sticky flag; clear wins over any increment in the same cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value <= '0;
         ovf   <= 1'b0;
      end else if (clear) begin
         value <= '0;
         ovf   <= 1'b0;
      end else if (count_en) begin
         if (sum[CTR_WIDTH]) begin
            ovf   <= 1'b1;
            value <= (SATURATE != 0) ? {CTR_WIDTH{1'b1}} : sum[CTR_WIDTH-1:0];
         end else begin
            value <= sum[CTR_WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/vx_perf_counter_bank.sv
// Bank of pipeline event counters read as 32-bit halves over a valid/ready port,
// with a shadow copy for tear-free 64-bit reads. VX_PERF_CTR_IRQ_EN adds irq.
module vx_perf_counter_bank
   import vx_perf_pkg::*;
#(
   parameter  int NUM_CTRS  = 8,
   parameter  int CTR_WIDTH = 44,
   parameter  int INC_WIDTH = 4,
   parameter  int SATURATE  = 0,
   localparam int IDX_W     = (NUM_CTRS > 1) ? $clog2(NUM_CTRS) : 1
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          count_en,
   input  logic                          clear,
   input  logic [NUM_CTRS*INC_WIDTH-1:0] inc_amt,
   input  logic                          rd_req_valid,
   output logic                          rd_req_ready,
   input  logic [IDX_W-1:0]              rd_req_idx,
   input  logic                          rd_req_hi,
   output logic                          rd_rsp_valid,
   input  logic                          rd_rsp_ready,
   output logic [PERF_RD_WORD_W-1:0]     rd_rsp_data,
   output logic [NUM_CTRS-1:0]           ovf_flags
`ifdef VX_PERF_CTR_IRQ_EN
   ,
   output logic                          irq
`endif
);

   perf_rd_req_t              req;
   logic [CTR_WIDTH-1:0]      ctr_val [NUM_CTRS];
   logic [PERF_CTR_MAX_W-1:0] live;
   logic [PERF_CTR_MAX_W-1:0] shadow;
   logic [PERF_IDX_W-1:0]     shadow_idx;
   logic [PERF_RD_WORD_W-1:0] rd_word;
   logic                      idx_ok;
   logic                      req_fire;

   assign req          = '{idx: PERF_IDX_W'(rd_req_idx), hi: rd_req_hi};
   assign idx_ok       = (int'(req.idx) < NUM_CTRS);
   assign rd_req_ready = !rd_rsp_valid || rd_rsp_ready;
   assign req_fire     = rd_req_valid && rd_req_ready;

   for (genvar g = 0; g < NUM_CTRS; g++) begin : g_ctr
      vx_perf_counter #(
         .CTR_WIDTH (CTR_WIDTH),
         .INC_WIDTH (INC_WIDTH),
         .SATURATE  (SATURATE)
      ) u_ctr (
         .clk      (clk),
         .reset    (reset),
         .clear    (clear),
         .count_en (count_en),
         .inc_amt  (inc_amt[g*INC_WIDTH +: INC_WIDTH]),
         .value    (ctr_val[g]),
         .ovf      (ovf_flags[g])
      );
   end

   // Select the registered counter value; zero-extension makes narrow counters read 0 above their width
   always_comb begin
      live = '0;
      for (int i = 0; i < NUM_CTRS; i++) begin
         live = live | ((int'(req.idx) == i) ? PERF_CTR_MAX_W'(ctr_val[i]) : '0);
      end
      if (!idx_ok) begin
         rd_word = '0;
      end else if (!req.hi) begin
         rd_word = live[PERF_RD_WORD_W-1:0];
      end else if (req.idx == shadow_idx) begin
         rd_word = shadow[PERF_CTR_MAX_W-1:PERF_RD_WORD_W];
      end else begin
         rd_word = live[PERF_CTR_MAX_W-1:PERF_RD_WORD_W];
      end
   end

   // Response register; a low-word read also snapshots the whole counter for the later high read
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_rsp_valid <= 1'b0;
         rd_rsp_data  <= '0;
         shadow       <= '0;
         shadow_idx   <= '0;
      end else if (req_fire) begin
         rd_rsp_valid <= 1'b1;
         rd_rsp_data  <= rd_word;
         if (idx_ok && !req.hi) begin
            shadow     <= live;
            shadow_idx <= req.idx;
         end
      end else if (rd_rsp_ready) begin
         rd_rsp_valid <= 1'b0;
      end
   end

`ifdef VX_PERF_CTR_IRQ_EN
   // Interrupt follows the flags one cycle later
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq <= 1'b0;
      end else begin
         irq <= |ovf_flags;
      end
   end
`endif

endmodule

// File: tb/tb_vx_perf_counter_bank.sv
// Scoreboard bench: three banks (44-bit wrap with wide increments, 8-bit wrap,
// 8-bit saturate) share stimulus and are checked against an arithmetic model.
module tb_vx_perf_counter_bank;

   localparam int NC = 6;

   typedef struct packed {
      logic [2:0][31:0] w;
   } exp_t;

   logic              clk;
   logic              reset;
   logic              count_en;
   logic              clear;
   logic [35:0]       inc_val [NC];
   logic [NC*36-1:0]  inc_a;
   logic [NC*4-1:0]   inc_b;
   logic              req_valid;
   logic [2:0]        req_idx;
   logic              req_hi;
   logic              rsp_ready;
   logic [2:0]        req_ready_w;
   logic [2:0]        rsp_valid_w;
   logic [2:0][31:0]  rsp_data_w;
   logic [2:0][NC-1:0] ovf_w;
`ifdef VX_PERF_CTR_IRQ_EN
   logic [2:0]        irq_w;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   exp_t sb[$];

   longint unsigned m_ctr [3][NC];
   logic [NC-1:0]   m_ovf [3];
   longint unsigned m_sh  [3];
   int              m_shidx [3];
   logic            m_valid;
   logic [2:0]      m_irq;

   for (genvar g = 0; g < NC; g++) begin : g_inc
      assign inc_a[g*36 +: 36] = inc_val[g];
      assign inc_b[g*4 +: 4]   = inc_val[g][3:0];
   end

   vx_perf_counter_bank #(.NUM_CTRS(NC), .CTR_WIDTH(44), .INC_WIDTH(36), .SATURATE(0)) dut_wide (
      .clk(clk), .reset(reset), .count_en(count_en), .clear(clear), .inc_amt(inc_a),
      .rd_req_valid(req_valid), .rd_req_ready(req_ready_w[0]), .rd_req_idx(req_idx),
      .rd_req_hi(req_hi), .rd_rsp_valid(rsp_valid_w[0]), .rd_rsp_ready(rsp_ready),
      .rd_rsp_data(rsp_data_w[0]), .ovf_flags(ovf_w[0])
`ifdef VX_PERF_CTR_IRQ_EN
      , .irq(irq_w[0])
`endif
   );

   vx_perf_counter_bank #(.NUM_CTRS(NC), .CTR_WIDTH(8), .INC_WIDTH(4), .SATURATE(0)) dut_wrap (
      .clk(clk), .reset(reset), .count_en(count_en), .clear(clear), .inc_amt(inc_b),
      .rd_req_valid(req_valid), .rd_req_ready(req_ready_w[1]), .rd_req_idx(req_idx),
      .rd_req_hi(req_hi), .rd_rsp_valid(rsp_valid_w[1]), .rd_rsp_ready(rsp_ready),
      .rd_rsp_data(rsp_data_w[1]), .ovf_flags(ovf_w[1])
`ifdef VX_PERF_CTR_IRQ_EN
      , .irq(irq_w[1])
`endif
   );

   vx_perf_counter_bank #(.NUM_CTRS(NC), .CTR_WIDTH(8), .INC_WIDTH(4), .SATURATE(1)) dut_sat (
      .clk(clk), .reset(reset), .count_en(count_en), .clear(clear), .inc_amt(inc_b),
      .rd_req_valid(req_valid), .rd_req_ready(req_ready_w[2]), .rd_req_idx(req_idx),
      .rd_req_hi(req_hi), .rd_rsp_valid(rsp_valid_w[2]), .rd_rsp_ready(rsp_ready),
      .rd_rsp_data(rsp_data_w[2]), .ovf_flags(ovf_w[2])
`ifdef VX_PERF_CTR_IRQ_EN
      , .irq(irq_w[2])
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wid(int d);
      return (d == 0) ? 44 : 8;
   endfunction

   task automatic chk(string name, int d, longint unsigned act, longint unsigned exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, d, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         for (int c = 0; c < NC; c++) m_ctr[d][c] = 0;
         m_ovf[d]   = '0;
         m_sh[d]    = 0;
         m_shidx[d] = 0;
      end
      m_valid = 1'b0;
      m_irq   = 3'b000;
      sb.delete();
   endtask

   task automatic idle();
      count_en  = 1'b0;
      clear     = 1'b0;
      for (int c = 0; c < NC; c++) inc_val[c] = 36'd0;
      req_valid = 1'b0;
      req_idx   = 3'd0;
      req_hi    = 1'b0;
      rsp_ready = 1'b1;
   endtask

   // One clock: check current state, apply the spec rules for the coming edge, then advance
   task automatic tick();
      logic exp_rdy;
      exp_t e;
      int   idx;
      #1;
      exp_rdy = !m_valid || rsp_ready;
      for (int d = 0; d < 3; d++) begin
         chk("req_ready", d, req_ready_w[d], exp_rdy);
         chk("rsp_valid", d, rsp_valid_w[d], m_valid);
         chk("ovf_flags", d, ovf_w[d], m_ovf[d]);
`ifdef VX_PERF_CTR_IRQ_EN
         chk("irq", d, irq_w[d], m_irq[d]);
`endif
      end
      idx = int'(req_idx);
      if (req_valid && exp_rdy) begin
         for (int d = 0; d < 3; d++) begin
            if (idx >= NC) begin
               e.w[d] = 32'd0;
            end else if (!req_hi) begin
               e.w[d]     = 32'(m_ctr[d][idx] % 64'h1_0000_0000);
               m_sh[d]    = m_ctr[d][idx];
               m_shidx[d] = idx;
            end else if (idx == m_shidx[d]) begin
               e.w[d] = 32'(m_sh[d] / 64'h1_0000_0000);
            end else begin
               e.w[d] = 32'(m_ctr[d][idx] / 64'h1_0000_0000);
            end
         end
         sb.push_back(e);
         m_valid = 1'b1;
      end else if (rsp_ready) begin
         m_valid = 1'b0;
      end
      for (int d = 0; d < 3; d++) begin
         m_irq[d] = (m_ovf[d] != '0);
         for (int c = 0; c < NC; c++) begin
            longint unsigned inc, lim, s;
            inc = (d == 0) ? 64'(inc_val[c]) : 64'(inc_val[c][3:0]);
            lim = 64'd1 << wid(d);
            if (clear) begin
               m_ctr[d][c] = 0;
               m_ovf[d][c] = 1'b0;
            end else if (count_en) begin
               s = m_ctr[d][c] + inc;
               if (s >= lim) begin
                  m_ovf[d][c] = 1'b1;
                  m_ctr[d][c] = (d == 2) ? lim - 1 : s - lim;
               end else begin
                  m_ctr[d][c] = s;
               end
            end
         end
      end
      @(posedge clk);
      #2;
   endtask

   task automatic rd(input logic [2:0] idx, input logic hi);
      req_valid = 1'b1;
      req_idx   = idx;
      req_hi    = hi;
      tick();
      req_valid = 1'b0;
   endtask

   // Monitor: compare the head of the scoreboard whenever a response is presented
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && (rsp_valid_w != 3'b000)) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL rsp_unexpected: got valid %b, expected no response", rsp_valid_w);
            end else begin
               for (int d = 0; d < 3; d++) begin
                  chk("rsp_valid_mon", d, rsp_valid_w[d], 1);
                  chk("rsp_data", d, rsp_data_w[d], sb[0].w[d]);
               end
               if (rsp_ready) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      for (int d = 0; d < 3; d++) begin
         chk("reset_rsp_valid", d, rsp_valid_w[d], 0);
         chk("reset_rsp_data", d, rsp_data_w[d], 0);
      end
      tick();

      // channel 2 counts, channel 5 is blocked by count_en
      count_en = 1'b1; inc_val[2] = 36'd3;
      repeat (5) tick();
      count_en = 1'b0; inc_val[2] = 36'd0; inc_val[5] = 36'd7;
      repeat (2) tick();
      inc_val[5] = 36'd0;
      rd(3'd2, 1'b0);
      rd(3'd5, 1'b0);
      tick();

      // 8-bit wrap / saturate on channel 0 from 254 by 3
      count_en = 1'b1; inc_val[0] = 36'd15;
      repeat (16) tick();
      inc_val[0] = 36'd14; tick();
      inc_val[0] = 36'd3;  tick();
      inc_val[0] = 36'd0;
      rd(3'd0, 1'b0);
      rd(3'd0, 1'b1);
      clear = 1'b1; tick(); clear = 1'b0;
      tick();

      // tear-free read across the 32-bit boundary, plus out-of-range indices
      inc_val[1] = 36'hFFFF_FFFF; tick();
      inc_val[1] = 36'd1;
      rd(3'd1, 1'b0);
      tick();
      tick();
      rd(3'd1, 1'b1);
      rd(3'd6, 1'b0);
      rd(3'd7, 1'b1);
      rd(3'd1, 1'b1);
      rd(3'd2, 1'b0);
      rd(3'd1, 1'b1);
      inc_val[1] = 36'd0;

      // backpressure, then accept with a same-cycle clear
      inc_val[3] = 36'd5; tick(); tick();
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_idx = 3'd3; req_hi = 1'b0;
      repeat (5) tick();
      rsp_ready = 1'b1; clear = 1'b1;
      tick();
      clear = 1'b0; req_valid = 1'b0;
      rd(3'd3, 1'b0);
      inc_val[3] = 36'd0;

      // wrap the wide counter with maximal increments
      inc_val[0] = 36'hF_FFFF_FFFF;
      repeat (258) tick();
      inc_val[0] = 36'd0;
      rd(3'd0, 1'b0);
      rd(3'd0, 1'b1);

      // asynchronous reset while a response is held
      rsp_ready = 1'b0;
      rd(3'd0, 1'b0);
      tick();
      #1;
      reset = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) begin
         chk("async_rsp_valid", d, rsp_valid_w[d], 0);
         chk("async_rsp_data", d, rsp_data_w[d], 0);
         chk("async_ovf", d, ovf_w[d], 0);
      end
      model_reset();
      idle();
      @(posedge clk);
      #2;
      reset = 1'b0;
      rd(3'd0, 1'b0);
      rd(3'd0, 1'b1);

      // randomized traffic
      for (int n = 0; n < 500; n++) begin
         count_en  = ($urandom_range(0, 3) != 0);
         clear     = ($urandom_range(0, 39) == 0);
         for (int c = 0; c < NC; c++) begin
            inc_val[c] = ($urandom_range(0, 3) == 0) ? {4'($urandom_range(0, 15)), 32'($urandom)}
                                                     : 36'($urandom_range(0, 15));
         end
         req_valid = 1'($urandom_range(0, 1));
         req_idx   = 3'($urandom_range(0, 7));
         req_hi    = 1'($urandom_range(0, 1));
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      // drain outstanding responses
      idle();
      for (int n = 0; n < 20 && sb.size() > 0; n++) tick();
      chk("scoreboard_drained", 0, sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
